// File: rtl/l2_core_arbiter.sv
// Per-core request FIFOs feeding a round-robin arbiter and a registered L2 output stage.
// Packets are flat vectors of PKT_W bits; the MSB is the valid flag, passed through unmodified.
module l2_core_arbiter #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned PKT_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CORES*PKT_W-1:0]   core_l2req_packet,
   output logic [NUM_CORES-1:0]         core_l2req_ready,
   output logic [PKT_W-1:0]             l2req_packet,
   input  logic                         l2_stall,
   output logic [$clog2(NUM_CORES)-1:0] grant_core,
   output logic                         pc_event_arb_conflict
);

   localparam int unsigned CW = $clog2(NUM_CORES);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned VB = PKT_W - 1;

   logic [PKT_W-1:0] mem_q    [NUM_CORES][FIFO_DEPTH];
   logic [PKT_W-1:0] mem_d    [NUM_CORES][FIFO_DEPTH];
   logic [AW-1:0]    rd_ptr_q [NUM_CORES];
   logic [AW-1:0]    rd_ptr_d [NUM_CORES];
   logic [AW-1:0]    wr_ptr_q [NUM_CORES];
   logic [AW-1:0]    wr_ptr_d [NUM_CORES];
   logic [NW-1:0]    count_q  [NUM_CORES];
   logic [NW-1:0]    count_d  [NUM_CORES];

   logic [PKT_W-1:0] pkt_q, pkt_d;
   logic [CW-1:0]    grant_q, grant_d;
   logic [CW-1:0]    last_q, last_d;
   logic             conf_q, conf_d;

   logic [NUM_CORES-1:0] push, pop, nonempty;
   logic                 adv;
   logic                 win_found;
   logic [CW-1:0]        win_idx;
   logic [CW-1:0]        cand;
   logic [CW:0]          ne_cnt;

   // Ready depends only on the stored count, so there is no valid-to-ready path.
   always_comb begin
      adv       = !pkt_q[VB] || !l2_stall;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      ne_cnt    = '0;
      nonempty  = '0;
      push      = '0;
      pop       = '0;
      core_l2req_ready = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         nonempty[i]         = (count_q[i] != '0);
         core_l2req_ready[i] = (count_q[i] != NW'(FIFO_DEPTH));
         push[i]             = core_l2req_packet[i*PKT_W + VB] && core_l2req_ready[i];
         if (nonempty[i]) ne_cnt = ne_cnt + (CW+1)'(1);
      end
      for (int unsigned k = 1; k <= NUM_CORES; k++) begin
         cand = CW'((32'(last_q) + k) % NUM_CORES);
         if (!win_found && nonempty[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      if (adv && win_found) pop[win_idx] = 1'b1;
   end

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pkt_d    = pkt_q;
      grant_d  = grant_q;
      last_d   = last_q;
      conf_d   = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = core_l2req_packet[i*PKT_W +: PKT_W];
            wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
         end
         if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
         case ({push[i], pop[i]})
            2'b10:   count_d[i] = count_q[i] + NW'(1);
            2'b01:   count_d[i] = count_q[i] - NW'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
      if (adv) begin
         if (win_found) begin
            pkt_d   = mem_q[win_idx][rd_ptr_q[win_idx]];
            grant_d = win_idx;
            last_d  = win_idx;
            conf_d  = (ne_cnt >= (CW+1)'(2));
         end else begin
            pkt_d[VB] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            for (int unsigned j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         pkt_q   <= '0;
         grant_q <= '0;
         last_q  <= CW'(NUM_CORES - 1);
         conf_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         pkt_q    <= pkt_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         conf_q   <= conf_d;
      end
   end

   assign l2req_packet          = pkt_q;
   assign grant_core            = grant_q;
   assign pc_event_arb_conflict = conf_q;

endmodule

// File: tb/tb_l2_core_arbiter.sv
// Bench for l2_core_arbiter: directed table, hand-written corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_l2_core_arbiter;

   localparam int NC = 4;
   localparam int FD = 2;
   localparam int PW = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NC*PW-1:0] core_pkt = '0;
   logic [NC-1:0]   ready;
   logic [PW-1:0]   l2_pkt;
   logic            l2_stall = 1'b0;
   logic [1:0]      grant;
   logic            conflict;

   int n_vec = 0;
   int n_err = 0;

   l2_core_arbiter #(.NUM_CORES(NC), .FIFO_DEPTH(FD), .PKT_W(PW)) dut (
      .clk                  (clk),
      .reset                (reset),
      .core_l2req_packet    (core_pkt),
      .core_l2req_ready     (ready),
      .l2req_packet         (l2_pkt),
      .l2_stall             (l2_stall),
      .grant_core           (grant),
      .pc_event_arb_conflict(conflict)
   );

   always #5 clk = ~clk;

   // Reference model: per-core queues, output register, round-robin pointer.
   logic [PW-1:0] mq [NC][$];
   logic          m_valid;
   logic [PW-1:0] m_pkt;
   int            m_grant;
   int            m_last;
   logic          m_conf;

   function automatic logic [PW-1:0] mkpkt(input int c, input int tag, input logic v);
      mkpkt = {v, 3'(c), 12'(tag)};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_valid = 1'b0; m_pkt = '0; m_grant = 0; m_last = NC - 1; m_conf = 1'b0;
   endtask

   task automatic model_edge();
      int  sz [NC];
      int  ne;
      int  w;
      int  c;
      bit  adv;
      adv = !m_valid || !l2_stall;
      ne = 0;
      for (int i = 0; i < NC; i++) begin
         sz[i] = mq[i].size();
         if (sz[i] > 0) ne++;
      end
      m_conf = 1'b0;
      if (adv) begin
         w = -1;
         for (int k = 1; k <= NC; k++) begin
            c = (m_last + k) % NC;
            if (w < 0 && sz[c] > 0) w = c;
         end
         if (w >= 0) begin
            m_pkt   = mq[w].pop_front();
            m_valid = 1'b1;
            m_grant = w;
            m_last  = w;
            m_conf  = (ne >= 2);
         end else begin
            m_valid = 1'b0;
         end
      end
      for (int i = 0; i < NC; i++)
         if (core_pkt[i*PW + PW-1] && sz[i] < FD) mq[i].push_back(core_pkt[i*PW +: PW]);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [NC-1:0] mr;
      for (int c = 0; c < NC; c++) mr[c] = (mq[c].size() < FD);
      chk("model.valid", 32'(l2_pkt[PW-1]), 32'(m_valid));
      chk("model.grant", 32'(grant), 32'(m_grant));
      chk("model.conflict", 32'(conflict), 32'(m_conf));
      chk("model.ready", 32'(ready), 32'(mr));
      if (m_valid) chk("model.packet", 32'(l2_pkt), 32'(m_pkt));
   endtask

   task automatic drive(input logic [NC-1:0] mask, input logic stall, input int tag);
      for (int c = 0; c < NC; c++) core_pkt[c*PW +: PW] = mkpkt(c, tag, mask[c]);
      l2_stall = stall;
   endtask

   task automatic step(input logic [NC-1:0] mask, input logic stall, input int tag);
      drive(mask, stall, tag);
      model_edge();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive('0, 1'b0, 0);
      @(posedge clk);
      #1;
      chk("reset.ready", 32'(ready), 32'hF);
      chk("reset.valid", 32'(l2_pkt[PW-1]), 32'h0);
      chk("reset.grant", 32'(grant), 32'h0);
      chk("reset.conflict", 32'(conflict), 32'h0);
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic [NC-1:0] vmask;
      logic          stall;
      logic          exp_valid;
      logic [1:0]    exp_grant;
      logic          exp_conf;
      logic [NC-1:0] exp_ready;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic [PW-1:0] held;
      int            nv;

      // Round-robin drain of four simultaneous pushes, then stall/back-pressure on core 1.
      tbl[0]  = '{4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'hF};
      tbl[1]  = '{4'h0, 1'b0, 1'b1, 2'd0, 1'b1, 4'hF};
      tbl[2]  = '{4'h0, 1'b0, 1'b1, 2'd1, 1'b1, 4'hF};
      tbl[3]  = '{4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'hF};
      tbl[4]  = '{4'h0, 1'b0, 1'b1, 2'd3, 1'b0, 4'hF};
      tbl[5]  = '{4'h0, 1'b0, 1'b0, 2'd3, 1'b0, 4'hF};
      tbl[6]  = '{4'h2, 1'b1, 1'b0, 2'd3, 1'b0, 4'hF};
      tbl[7]  = '{4'h2, 1'b1, 1'b1, 2'd1, 1'b0, 4'hF};
      tbl[8]  = '{4'h2, 1'b1, 1'b1, 2'd1, 1'b0, 4'hD};
      tbl[9]  = '{4'h2, 1'b1, 1'b1, 2'd1, 1'b0, 4'hD};
      tbl[10] = '{4'h2, 1'b1, 1'b1, 2'd1, 1'b0, 4'hD};
      tbl[11] = '{4'h2, 1'b0, 1'b1, 2'd1, 1'b0, 4'hF};
      tbl[12] = '{4'h2, 1'b0, 1'b1, 2'd1, 1'b0, 4'hF};
      tbl[13] = '{4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'hF};
      tbl[14] = '{4'h0, 1'b0, 1'b0, 2'd1, 1'b0, 4'hF};

      do_reset();
      for (int r = 0; r < 15; r++) begin
         step(tbl[r].vmask, tbl[r].stall, r);
         chk($sformatf("tbl%0d.valid", r), 32'(l2_pkt[PW-1]), 32'(tbl[r].exp_valid));
         chk($sformatf("tbl%0d.grant", r), 32'(grant), 32'(tbl[r].exp_grant));
         chk($sformatf("tbl%0d.conflict", r), 32'(conflict), 32'(tbl[r].exp_conf));
         chk($sformatf("tbl%0d.ready", r), 32'(ready), 32'(tbl[r].exp_ready));
      end

      // Single request latency on core 2.
      do_reset();
      step(4'b0100, 1'b0, 'hA);
      chk("single.valid_e0", 32'(l2_pkt[PW-1]), 32'h0);
      step(4'b0000, 1'b0, 0);
      chk("single.valid_e1", 32'(l2_pkt[PW-1]), 32'h1);
      chk("single.grant", 32'(grant), 32'h2);
      chk("single.packet", 32'(l2_pkt), 32'(mkpkt(2, 'hA, 1'b1)));
      chk("single.conflict", 32'(conflict), 32'h0);
      step(4'b0000, 1'b0, 0);
      chk("single.valid_e2", 32'(l2_pkt[PW-1]), 32'h0);
      chk("single.conflict2", 32'(conflict), 32'h0);

      // Stall hold for five cycles, then release.
      do_reset();
      step(4'b0011, 1'b0, 5);
      step(4'b0000, 1'b1, 0);
      held = l2_pkt;
      chk("stall.first", 32'(held), 32'(mkpkt(0, 5, 1'b1)));
      for (int i = 0; i < 5; i++) begin
         step(4'b0000, 1'b1, 0);
         chk("stall.hold_pkt", 32'(l2_pkt), 32'(held));
         chk("stall.hold_grant", 32'(grant), 32'h0);
      end
      step(4'b0000, 1'b0, 0);
      chk("stall.release_grant", 32'(grant), 32'h1);
      chk("stall.release_pkt", 32'(l2_pkt), 32'(mkpkt(1, 5, 1'b1)));

      // Fairness: cores 0 and 3 always requesting.
      do_reset();
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         step(4'b1001, 1'b0, i);
         if (l2_pkt[PW-1]) begin
            chk("fair.grant", 32'(grant), (nv % 2 == 0) ? 32'h0 : 32'h3);
            nv++;
         end
      end
      chk("fair.count", 32'(nv), 32'd11);

      // Asynchronous reset mid-stream; round-robin pointer must restart.
      do_reset();
      step(4'b0001, 1'b0, 1);
      step(4'b0000, 1'b0, 0);
      step(4'b0110, 1'b1, 2);
      step(4'b0000, 1'b1, 0);
      chk("midrst.pre_valid", 32'(l2_pkt[PW-1]), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("midrst.ready", 32'(ready), 32'hF);
      chk("midrst.valid", 32'(l2_pkt[PW-1]), 32'h0);
      chk("midrst.grant", 32'(grant), 32'h0);
      chk("midrst.conflict", 32'(conflict), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      step(4'b0011, 1'b0, 3);
      chk("midrst.empty_after", 32'(l2_pkt[PW-1]), 32'h0);
      step(4'b0000, 1'b0, 0);
      chk("midrst.first_grant", 32'(grant), 32'h0);
      chk("midrst.first_pkt", 32'(l2_pkt), 32'(mkpkt(0, 3, 1'b1)));
      step(4'b0000, 1'b0, 0);
      chk("midrst.second_grant", 32'(grant), 32'h1);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++)
         step(NC'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3), i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
